// File: rtl/rgmii_tx_framer.sv
// rgmii_tx_framer: MAC-side RGMII transmit framer (preamble/SFD, pad, CRC-32 FCS, IFG)
// Ports: mac_clk/mac_rst_n clock and async active-low reset; mac_* byte stream in
// with mac_ready handshake; tx_rgmii_d1/d2 rising/falling nibbles and ctl1/ctl2
// (TX_EN, TX_EN^TX_ER) for external ODDRs; tx_busy while framing; tx_underrun pulse.
module rgmii_tx_framer #(
  parameter int DATA_WIDTH   = 8,
  parameter int PREAMBLE_LEN = 7,
  parameter int MIN_FRAME    = 60,
  parameter int APPEND_FCS   = 1,
  parameter int IFG_BYTES    = 12
) (
  input  logic                  mac_clk,
  input  logic                  mac_rst_n,
  input  logic                  mac_startofpacket,
  input  logic                  mac_endofpacket,
  input  logic                  mac_valid,
  input  logic [DATA_WIDTH-1:0] mac_data,
  input  logic                  mac_error,
  output logic                  mac_ready,
  output logic [3:0]            tx_rgmii_d1,
  output logic [3:0]            tx_rgmii_d2,
  output logic                  tx_rgmii_ctl1,
  output logic                  tx_rgmii_ctl2,
  output logic                  tx_busy,
  output logic                  tx_underrun
);
  typedef enum logic [2:0] {S_IDLE, S_PREAMBLE, S_DATA, S_PAD, S_FCS, S_IFG, S_DROP} state_t;
  localparam logic [7:0]  PRE_LAST = 8'(PREAMBLE_LEN - 1);
  localparam logic [7:0]  IFG_LAST = 8'(IFG_BYTES - 1);
  localparam logic [15:0] MIN_LEN  = 16'(MIN_FRAME);
  localparam state_t      S_POST   = (APPEND_FCS != 0) ? S_FCS : S_IFG;
  state_t      r_state, w_next;
  logic [7:0]  r_cnt, w_cnt;
  logic [15:0] r_len, w_len, w_len_inc;
  logic [31:0] r_crc, w_crc, w_fcs;
  logic [7:0]  r_byte, w_byte;
  logic        r_en, w_en, r_er, w_er, r_ur, w_ur, w_ready;
  function automatic logic [31:0] crc8(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] x;
    x = c;
    for (int i = 0; i < 8; i++) x = (x >> 1) ^ ((x[0] ^ d[i]) ? 32'hEDB88320 : 32'h0);
    return x;
  endfunction
  assign w_len_inc = (r_len == 16'hFFFF) ? r_len : r_len + 16'd1;
  assign w_fcs     = ~r_crc;
  // Output registers are loaded with the byte for the next cycle, so the state
  // leads the wire by one cycle: SFD is on the wire while S_DATA accepts byte 0.
  always_comb begin
    w_next  = r_state;
    w_len   = r_len;
    w_crc   = r_crc;
    w_byte  = 8'h00;
    w_en    = 1'b0;
    w_er    = 1'b0;
    w_ur    = 1'b0;
    w_ready = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_ready = mac_valid && !mac_startofpacket;
        w_en    = mac_valid && mac_startofpacket;
        w_byte  = w_en ? 8'h55 : 8'h00;
        w_next  = w_en ? S_PREAMBLE : S_IDLE;
      end
      S_PREAMBLE: begin
        w_en   = 1'b1;
        w_byte = (r_cnt == PRE_LAST) ? 8'hD5 : 8'h55;
        w_next = (r_cnt == PRE_LAST) ? S_DATA : S_PREAMBLE;
      end
      S_DATA: begin
        w_ready = 1'b1;
        w_en    = 1'b1;
        w_er    = mac_valid ? mac_error : 1'b1;
        w_ur    = !mac_valid;
        w_byte  = mac_valid ? mac_data[7:0] : 8'h00;
        w_crc   = mac_valid ? crc8(r_crc, mac_data[7:0]) : r_crc;
        w_len   = mac_valid ? w_len_inc : r_len;
        w_next  = !mac_valid ? S_DROP :
                  !mac_endofpacket ? S_DATA :
                  (w_len_inc < MIN_LEN) ? S_PAD : S_POST;
      end
      S_PAD: begin
        w_en   = 1'b1;
        w_crc  = crc8(r_crc, 8'h00);
        w_len  = w_len_inc;
        w_next = (w_len_inc >= MIN_LEN) ? S_POST : S_PAD;
      end
      S_FCS: begin
        w_en   = 1'b1;
        w_byte = w_fcs[{r_cnt[1:0], 3'b000} +: 8];
        w_next = (r_cnt == 8'd3) ? S_IFG : S_FCS;
      end
      S_IFG: begin
        w_next = (r_cnt == IFG_LAST) ? S_IDLE : S_IFG;
        w_crc  = (r_cnt == IFG_LAST) ? 32'hFFFFFFFF : r_crc;
        w_len  = (r_cnt == IFG_LAST) ? 16'd0 : r_len;
      end
      S_DROP: begin
        w_ready = 1'b1;
        w_next  = (mac_valid && mac_endofpacket) ? S_IFG : S_DROP;
      end
      default: w_next = S_IDLE;
    endcase
    w_cnt = (w_next == r_state) ? r_cnt + 8'd1 : 8'd0;
  end
  always_ff @(posedge mac_clk or negedge mac_rst_n) begin
    if (!mac_rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= 8'd0;
      r_len   <= 16'd0;
      r_crc   <= 32'hFFFFFFFF;
      r_byte  <= 8'h00;
      r_en    <= 1'b0;
      r_er    <= 1'b0;
      r_ur    <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt;
      r_len   <= w_len;
      r_crc   <= w_crc;
      r_byte  <= w_byte;
      r_en    <= w_en;
      r_er    <= w_er;
      r_ur    <= w_ur;
    end
  end
  // Ready is combinational; gate it so every output is low while reset is held.
  assign mac_ready     = mac_rst_n && w_ready;
  assign tx_rgmii_d1   = r_byte[3:0];
  assign tx_rgmii_d2   = r_byte[7:4];
  assign tx_rgmii_ctl1 = r_en;
  assign tx_rgmii_ctl2 = r_en ^ r_er;
  assign tx_busy       = r_state != S_IDLE;
  assign tx_underrun   = r_ur;
endmodule
